// File: rtl/axi_rd_responder_if.sv
// AXI4 read-channel bundle (AR + R) between a read master and the responder.
interface axi_rd_responder_if #(
  parameter int unsigned ADDR_WIDTH = 33,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ID_WIDTH   = 5
);
  logic                  ARVALID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [ID_WIDTH-1:0]   ARID;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  ARREADY;
  logic                  RVALID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic                  RLAST;
  logic [ID_WIDTH-1:0]   RID;
  logic [1:0]            RRESP;
  logic                  RREADY;

  modport master (
    output ARVALID, ARADDR, ARID, ARLEN, ARSIZE, ARBURST, RREADY,
    input  ARREADY, RVALID, RDATA, RLAST, RID, RRESP
  );

  modport slave (
    input  ARVALID, ARADDR, ARID, ARLEN, ARSIZE, ARBURST, RREADY,
    output ARREADY, RVALID, RDATA, RLAST, RID, RRESP
  );
endinterface

// File: rtl/axi_rd_responder.sv
// AXI4 read responder: queues AR requests in order and replays each as an INCR
// burst whose 64-bit lanes carry the beat address, after a programmable latency.
module axi_rd_responder #(
  parameter int unsigned ADDR_WIDTH = 33,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ID_WIDTH   = 5,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [15:0]              cfg_latency,
  axi_rd_responder_if.slave        s_axi,
  output logic [63:0]              ar_count,
  output logic [63:0]              rlast_count
);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned Lanes = DATA_WIDTH / 64;
  localparam logic [2:0]  SizeExp   = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [ADDR_WIDTH-1:0] BeatBytes = ADDR_WIDTH'(DATA_WIDTH / 8);

  typedef enum logic {StIdle, StBurst} state_e;

  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [ID_WIDTH-1:0]   fifo_id_q   [FIFO_DEPTH];
  logic [7:0]            fifo_len_q  [FIFO_DEPTH];
  logic                  fifo_err_q  [FIFO_DEPTH];
  logic [31:0]           fifo_ts_q   [FIFO_DEPTH];

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [31:0]           now_q, now_d;
  logic                  arready_q, arready_d;
  state_e                state_q, state_d;
  logic                  rvalid_q, rvalid_d, rlast_q, rlast_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0] beat_addr_q, beat_addr_d;
  logic [7:0]            beat_idx_q, beat_idx_d, len_q, len_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [63:0]           ar_count_q, ar_count_d, rlast_count_q, rlast_count_d;

  logic        push, pop, r_hs, head_ready, push_err;
  logic [31:0] lat_eff, head_age;

  always_comb begin
    push       = s_axi.ARVALID & arready_q;
    push_err   = (s_axi.ARBURST != 2'b01) | (s_axi.ARSIZE != SizeExp);
    r_hs       = rvalid_q & s_axi.RREADY;
    lat_eff    = (cfg_latency == 16'd0) ? 32'd1 : {16'd0, cfg_latency};
    // Age is modular so the free-running counter may wrap freely.
    head_age   = now_q - fifo_ts_q[rd_ptr_q];
    head_ready = (count_q != '0) && (head_age >= lat_eff);
    pop        = (state_q == StIdle) && head_ready;

    now_d         = now_q + 32'd1;
    wr_ptr_d      = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d       = count_q + CntW'(push) - CntW'(pop);
    arready_d     = (count_d != CntW'(FIFO_DEPTH));
    ar_count_d    = push ? ar_count_q + 64'd1 : ar_count_q;
    rlast_count_d = rlast_count_q;

    state_d     = state_q;
    rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;
    err_d       = err_q;
    beat_addr_d = beat_addr_q;
    beat_idx_d  = beat_idx_q;
    len_d       = len_q;
    id_d        = id_q;

    unique case (state_q)
      StIdle: begin
        if (head_ready) begin
          state_d     = StBurst;
          rvalid_d    = 1'b1;
          beat_addr_d = fifo_addr_q[rd_ptr_q];
          beat_idx_d  = 8'd0;
          len_d       = fifo_len_q[rd_ptr_q];
          id_d        = fifo_id_q[rd_ptr_q];
          err_d       = fifo_err_q[rd_ptr_q];
          rlast_d     = (fifo_len_q[rd_ptr_q] == 8'd0);
        end
      end
      StBurst: begin
        if (r_hs) begin
          if (rlast_q) begin
            state_d       = StIdle;
            rvalid_d      = 1'b0;
            rlast_d       = 1'b0;
            rlast_count_d = rlast_count_q + 64'd1;
          end else begin
            beat_idx_d  = beat_idx_q + 8'd1;
            beat_addr_d = beat_addr_q + BeatBytes;
            rlast_d     = (beat_idx_d == len_q);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= s_axi.ARADDR;
      fifo_id_q[wr_ptr_q]   <= s_axi.ARID;
      fifo_len_q[wr_ptr_q]  <= s_axi.ARLEN;
      fifo_err_q[wr_ptr_q]  <= push_err;
      fifo_ts_q[wr_ptr_q]   <= now_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      now_q         <= '0;
      arready_q     <= 1'b0;
      state_q       <= StIdle;
      rvalid_q      <= 1'b0;
      rlast_q       <= 1'b0;
      err_q         <= 1'b0;
      beat_addr_q   <= '0;
      beat_idx_q    <= '0;
      len_q         <= '0;
      id_q          <= '0;
      ar_count_q    <= '0;
      rlast_count_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      now_q         <= now_d;
      arready_q     <= arready_d;
      state_q       <= state_d;
      rvalid_q      <= rvalid_d;
      rlast_q       <= rlast_d;
      err_q         <= err_d;
      beat_addr_q   <= beat_addr_d;
      beat_idx_q    <= beat_idx_d;
      len_q         <= len_d;
      id_q          <= id_d;
      ar_count_q    <= ar_count_d;
      rlast_count_q <= rlast_count_d;
    end
  end

  assign s_axi.ARREADY = arready_q;
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RLAST   = rlast_q;
  assign s_axi.RID     = id_q;
  assign s_axi.RRESP   = {err_q, 1'b0};
  assign s_axi.RDATA   = {Lanes{64'(beat_addr_q)}};
  assign ar_count      = ar_count_q;
  assign rlast_count   = rlast_count_q;
endmodule

// File: tb/tb_axi_rd_responder.sv
// Randomized and directed bench for axi_rd_responder against a cycle-level
// request/burst model; directed scenarios pin the model with literal values.
module tb_axi_rd_responder;
  localparam int unsigned AW = 33, DW = 256, IW = 5, DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_latency;
  logic [63:0] ar_count, rlast_count;

  axi_rd_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  axi_rd_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_latency(cfg_latency), .s_axi(bus),
    .ar_count(ar_count), .rlast_count(rlast_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr; logic [IW-1:0] id; logic [7:0] len; logic [2:0] size; logic [1:0] burst;
  } ar_t;
  typedef struct {
    logic [AW-1:0] addr; logic [IW-1:0] id; logic [7:0] len; logic err; int t;
  } req_t;
  typedef struct {
    int cyc; logic [63:0] lane0; logic [IW-1:0] id; logic [1:0] resp; logic last;
  } beat_t;

  int          total = 0, bad = 0;
  ar_t         dir_q[$];
  req_t        m_q[$];
  beat_t       blog[$];
  int          alog[$];
  req_t        m_cur;
  logic        m_active, exp_arready, arvalid_hold;
  int          m_beat, m_cyc = 0;
  logic [63:0] m_arc, m_rlc, b_ar, b_rl;
  int          rmode, ar_pct;
  logic [15:0] lat_next;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] lanes(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 64; i++) v[i*64 +: 64] = 64'(a);
    return v;
  endfunction

  function automatic ar_t rand_ar();
    ar_t r;
    r.addr  = ($urandom_range(0, 7) == 0) ? 33'h1_FFFF_FFC0 :
              {1'($urandom_range(0, 1)), 32'($urandom)};
    r.id    = IW'($urandom);
    r.len   = 8'($urandom_range(0, 7));
    r.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd5;
    r.burst = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b01;
    return r;
  endfunction

  function automatic ar_t mk_ar(input logic [AW-1:0] a, input logic [IW-1:0] id,
                                input logic [7:0] len, input logic [1:0] burst);
    ar_t r;
    r.addr = a; r.id = id; r.len = len; r.size = 3'd5; r.burst = burst;
    return r;
  endfunction

  task automatic put(input ar_t r);
    bus.ARVALID = 1'b1; bus.ARADDR = r.addr; bus.ARID = r.id;
    bus.ARLEN = r.len; bus.ARSIZE = r.size; bus.ARBURST = r.burst;
  endtask

  task automatic model_reset();
    m_q.delete(); dir_q.delete(); blog.delete(); alog.delete();
    m_active = 1'b0; m_beat = 0; m_arc = '0; m_rlc = '0;
    exp_arready = 1'b1; arvalid_hold = 1'b0;
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model.
  task automatic step();
    logic          ar_hs, r_hs, was_active;
    logic [AW-1:0] ba;
    req_t          nr;
    int            lat;
    @(negedge clk);
    chk("arready", DW'(bus.ARREADY), DW'(exp_arready));
    chk("rvalid", DW'(bus.RVALID), DW'(m_active));
    chk("ar_count", DW'(ar_count), DW'(m_arc));
    chk("rlast_count", DW'(rlast_count), DW'(m_rlc));
    if (m_active) begin
      ba = m_cur.addr + AW'(m_beat) * AW'(32);
      chk("rdata", bus.RDATA, lanes(ba));
      chk("rlast", DW'(bus.RLAST), DW'(m_beat == int'(m_cur.len)));
      chk("rid", DW'(bus.RID), DW'(m_cur.id));
      chk("rresp", DW'(bus.RRESP), DW'(m_cur.err ? 2'b10 : 2'b00));
    end
    cfg_latency = lat_next;
    if (!arvalid_hold) begin
      if (dir_q.size() > 0) put(dir_q.pop_front());
      else if (ar_pct > 0 && $urandom_range(0, 99) < ar_pct) put(rand_ar());
      else bus.ARVALID = 1'b0;
    end
    case (rmode)
      0: bus.RREADY = 1'b0;
      1: bus.RREADY = 1'b1;
      2: bus.RREADY = ~bus.RREADY;
      default: bus.RREADY = ($urandom_range(0, 3) != 0);
    endcase
    if (bus.RVALID && bus.RREADY)
      blog.push_back('{m_cyc, bus.RDATA[63:0], bus.RID, bus.RRESP, bus.RLAST});
    ar_hs      = bus.ARVALID && exp_arready;
    r_hs       = m_active && bus.RREADY;
    was_active = m_active;
    if (r_hs) begin
      if (m_beat == int'(m_cur.len)) begin m_active = 1'b0; m_rlc++; end
      else m_beat++;
    end
    lat = (cfg_latency == 16'd0) ? 1 : int'(cfg_latency);
    if (!was_active && m_q.size() > 0 && (m_cyc - m_q[0].t) >= lat) begin
      m_cur = m_q.pop_front(); m_active = 1'b1; m_beat = 0;
    end
    if (ar_hs) begin
      nr.addr = bus.ARADDR; nr.id = bus.ARID; nr.len = bus.ARLEN; nr.t = m_cyc;
      nr.err  = (bus.ARBURST != 2'b01) || (bus.ARSIZE != 3'd5);
      m_q.push_back(nr); m_arc++; alog.push_back(m_cyc);
    end
    exp_arready  = (m_q.size() < DEPTH);
    arvalid_hold = bus.ARVALID && !ar_hs;
    m_cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((m_active || m_q.size() != 0 || dir_q.size() != 0 || arvalid_hold) && n < limit) begin
      step(); n++;
    end
    if (n >= limit) begin
      total++; bad++;
      $display("FAIL drain: still busy after %0d cycles, want idle", limit);
    end
    run(2);
  endtask

  task automatic new_test();
    blog.delete(); alog.delete(); b_ar = m_arc; b_rl = m_rlc;
  endtask

  initial begin
    rst_n = 1'b0; cfg_latency = '0; lat_next = '0; rmode = 1; ar_pct = 0;
    bus.ARVALID = 1'b0; bus.ARADDR = '0; bus.ARID = '0; bus.ARLEN = '0;
    bus.ARSIZE = 3'd5; bus.ARBURST = 2'b01; bus.RREADY = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst arready", DW'(bus.ARREADY), '0);
    chk("rst rvalid", DW'(bus.RVALID), '0);
    chk("rst rlast", DW'(bus.RLAST), '0);
    chk("rst rdata", bus.RDATA, '0);
    chk("rst rid", DW'(bus.RID), '0);
    chk("rst rresp", DW'(bus.RRESP), '0);
    chk("rst ar_count", DW'(ar_count), '0);
    chk("rst rlast_count", DW'(rlast_count), '0);
    @(negedge clk); rst_n = 1'b1; model_reset();

    // Minimum latency, two-beat burst.
    new_test(); lat_next = 16'd0; rmode = 1;
    dir_q.push_back(mk_ar(33'h100, 5'd1, 8'd1, 2'b01));
    wait_idle(100);
    chk("t1 nbeats", DW'(blog.size()), DW'(2));
    if (blog.size() == 2 && alog.size() == 1) begin
      chk("t1 first cyc", DW'(blog[0].cyc - alog[0]), DW'(2));
      chk("t1 second cyc", DW'(blog[1].cyc - alog[0]), DW'(3));
      chk("t1 lane0 b0", DW'(blog[0].lane0), DW'(64'h100));
      chk("t1 lane0 b1", DW'(blog[1].lane0), DW'(64'h120));
      chk("t1 last", DW'({blog[0].last, blog[1].last}), DW'(2'b01));
      chk("t1 resp", DW'({blog[0].resp, blog[1].resp}), DW'(4'b0000));
    end
    chk("t1 ar_count", DW'(ar_count), DW'(1));
    chk("t1 rlast_count", DW'(rlast_count), DW'(1));

    // Long latency, ID echo.
    new_test(); lat_next = 16'd100;
    dir_q.push_back(mk_ar(33'h2000, 5'd5, 8'd3, 2'b01));
    wait_idle(300);
    chk("t2 nbeats", DW'(blog.size()), DW'(4));
    if (blog.size() == 4 && alog.size() == 1) begin
      chk("t2 first cyc", DW'(blog[0].cyc - alog[0]), DW'(101));
      chk("t2 last cyc", DW'(blog[3].cyc - alog[0]), DW'(104));
      for (int i = 0; i < 4; i++) chk("t2 rid", DW'(blog[i].id), DW'(5));
    end

    // Toggling RREADY over an 8-beat burst.
    new_test(); lat_next = 16'd0; rmode = 2;
    dir_q.push_back(mk_ar(33'h4000, 5'd2, 8'd7, 2'b01));
    wait_idle(100);
    chk("t3 nbeats", DW'(blog.size()), DW'(8));
    if (blog.size() == 8)
      for (int i = 0; i < 8; i++) begin
        chk("t3 addr", DW'(blog[i].lane0), DW'(64'h4000 + 64'(i * 32)));
        chk("t3 last", DW'(blog[i].last), DW'(i == 7));
      end

    // Fill the FIFO while nothing drains, then release.
    new_test(); lat_next = 16'd1000; rmode = 0;
    for (int i = 0; i < 10; i++)
      dir_q.push_back(mk_ar(AW'(32'h1_0000 * (i + 1)), IW'(i), 8'd1, 2'b01));
    run(20);
    chk("t4 full arready", DW'(bus.ARREADY), '0);
    chk("t4 ar accepted", DW'(ar_count - b_ar), DW'(8));
    lat_next = 16'd0; rmode = 1;
    wait_idle(500);
    chk("t4 ar total", DW'(ar_count - b_ar), DW'(10));
    chk("t4 rlast total", DW'(rlast_count - b_rl), DW'(10));
    chk("t4 nbeats", DW'(blog.size()), DW'(20));
    if (blog.size() == 20)
      for (int i = 0; i < 10; i++) chk("t4 order", DW'(blog[2*i+1].id), DW'(i));

    // Unsupported burst type still returns the full burst.
    new_test();
    dir_q.push_back(mk_ar(33'h5000, 5'd3, 8'd2, 2'b00));
    wait_idle(100);
    chk("t5 nbeats", DW'(blog.size()), DW'(3));
    if (blog.size() == 3)
      for (int i = 0; i < 3; i++) begin
        chk("t5 resp", DW'(blog[i].resp), DW'(2'b10));
        chk("t5 last", DW'(blog[i].last), DW'(i == 2));
      end

    // Randomized traffic across several latencies.
    for (int r = 0; r < 4; r++) begin
      new_test(); rmode = 3; ar_pct = 40;
      lat_next = 16'($urandom_range(0, 3) * 6);
      run(150);
      ar_pct = 0;
      wait_idle(3000);
    end

    // Reset in the middle of a long burst.
    new_test(); lat_next = 16'd0; rmode = 1;
    dir_q.push_back(mk_ar(33'h6000, 5'd7, 8'd15, 2'b01));
    run(6);
    chk("t6 mid burst", DW'(bus.RVALID), DW'(1));
    #1 rst_n = 1'b0; bus.ARVALID = 1'b0;
    #1;
    chk("t6 rvalid async", DW'(bus.RVALID), '0);
    chk("t6 ar_count clr", DW'(ar_count), '0);
    chk("t6 rlast_count clr", DW'(rlast_count), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; model_reset();
    run(30);
    chk("t6 no beats", DW'(blog.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_rd_responder.md
# axi_rd_responder

AXI4 read-channel responder (subordinate) that answers AR requests with R bursts after a programmable latency, returning address-derived data. It is the far end of the read engine's AXI master port: used as a memory stand-in for loopback benchmarking and as the self-checking target for read-path verification. Requests are queued in an in-order FIFO and served one burst at a time.

## Interface
- ADDR_WIDTH, 33, byte address width
- DATA_WIDTH, 256, R data width; 256 or 512 only
- ID_WIDTH, 5, AXI ID width
- FIFO_DEPTH, 8, outstanding AR entries; power of two, ≥2
---
- clk  in  1  single clock
- rst_n  in  1  reset; asynchronous, active-low
- cfg_latency  in  16  minimum cycles from AR acceptance to eligibility; sampled live
- s_axi_ARVALID  in  1  read address valid
- s_axi_ARADDR  in  ADDR_WIDTH  byte address
- s_axi_ARID  in  ID_WIDTH  request ID
- s_axi_ARLEN  in  8  beats minus 1
- s_axi_ARSIZE  in  3  expected 3'b101 (256) / 3'b110 (512)
- s_axi_ARBURST  in  2  expected 2'b01 (INCR)
- s_axi_ARREADY  out  1  address accepted
- s_axi_RVALID  out  1  read data valid
- s_axi_RDATA  out  DATA_WIDTH  read data
- s_axi_RLAST  out  1  last beat of burst
- s_axi_RID  out  ID_WIDTH  echoed ARID
- s_axi_RRESP  out  2  00 OKAY, 10 SLVERR
- s_axi_RREADY  in  1  master accepts beat
- ar_count  out  64  accepted AR handshakes
- rlast_count  out  64  accepted RLAST beats

## Operation
- Free-running 32-bit cycle counter `now`, wraps; ages computed modulo 2^32.
- AR handshake (ARVALID & ARREADY): push {ARADDR, ARID, ARLEN, err, ts=now}; err = (ARBURST≠01) | (ARSIZE≠log2(DATA_WIDTH/8)); ar_count++.
- ARREADY = ~full, registered from occupancy; no same-cycle bypass when full even if a pop occurs.
- FSM states: IDLE, BURST.
  - IDLE: if FIFO non-empty and (now − head.ts) ≥ max(cfg_latency,1): pop head, load beat_addr=ARADDR, beat_idx=0, len, id, err; go BURST (RVALID high next cycle).
  - BURST: RVALID=1; RDATA = every 64-bit lane holds beat_addr zero-extended; RID=id; RRESP = err ? 10 : 00 on every beat; RLAST = (beat_idx==len).
  - On RVALID&RREADY: if RLAST → rlast_count++, go IDLE; else beat_idx++, beat_addr += DATA_WIDTH/8 (ADDR_WIDTH wrap, no 4KB check).
- Erroneous bursts still return ARLEN+1 beats, data computed as INCR.
- R outputs held stable while RVALID & ~RREADY.
- Bursts returned strictly in acceptance order; ID ignored for ordering.

## Timing
- Reset (async assert, sync release): ARREADY=0, RVALID=0, RLAST=0, RDATA=0, RID=0, RRESP=0, ar_count=0, rlast_count=0, now=0, FIFO empty, FSM IDLE; ARREADY=1 first cycle after release.
- AR accepted in cycle T with idle FSM/empty FIFO: first RVALID in cycle T+max(cfg_latency,1)+1; cfg_latency=0 or 1 → T+2.
- One idle cycle (RVALID=0) between RLAST handshake and next burst's first beat.
- Beat throughput 1/cycle while RREADY=1.
- Full FIFO: ARREADY=0 cycle after occupancy reaches FIFO_DEPTH; returns to 1 cycle after a pop.
- cfg_latency change affects only the current head evaluation; no re-timing of in-flight burst.
- Reset mid-burst: RVALID drops immediately (async), queued requests discarded, counters cleared.
- Counters wrap at 2^64; both update the cycle after their handshake.

## Test plan
- cfg_latency=0, one AR addr 0x100 ARLEN=1 at cycle T, RREADY=1 → RVALID at T+2, T+3; lanes 0x100 then 0x120 (256-bit); RLAST on second; RRESP=00; counts 1/1.
- cfg_latency=100, ARLEN=3, ARID=5 → first RVALID at T+101; 4 beats RID=5; fifth cycle RVALID=0.
- RREADY toggling 1-0-1-0 during 8-beat burst → outputs stable on stall cycles, beat addresses increase by 32 only on handshakes, exactly 8 beats.
- RREADY=0, issue 10 ARs back-to-back, FIFO_DEPTH=8 → ARREADY low after 8 accepted (ar_count=8); release RREADY → remaining 2 accepted, 10 bursts in order, rlast_count=10.
- ARBURST=00 ARLEN=2 → 3 beats all RRESP=10, RLAST on third.
- Assert rst_n low mid-burst of ARLEN=15 → RVALID=0 same cycle, counts 0, no further beats after release until new AR.
